output_error_gen: RTL

OUTPUT_ERROR_GEN -- requirements
Module: output_error_gen

---
 rtl/nn_pack.sv | 36 +++
 rtl/dv_if.sv | 13 +
 rtl/error_mult_sat.sv | 60 ++++++
 rtl/output_error_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/nn_pack.sv
// Shared types and helpers for the output error generator.
//   state_t  : controller states (IDLE, COLLECT, FLUSH, STREAM)
//   SAT_W    : working width of the saturation helper; every intermediate
//              value handed to sat_clip must fit in this many bits
//   sat_clip : clamps a sign-extended value to a signed range of 'width' bits
package nn_pack;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    STREAM  = 2'd3
  } state_t;

  localparam int SAT_W = 64;

  // Returns value limited to [-(2**(width-1)), 2**(width-1)-1]. The caller
  // detects saturation by comparing the result against its input.
  function automatic logic signed [SAT_W-1:0] sat_clip(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    lo = ~hi;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/dv_if.sv
// Data/valid stream bundle (no back-pressure).
//   valid : data is meaningful this cycle
//   data  : W-bit payload
// master drives the bundle, slave observes it.
interface dv_if #(
  parameter int W = 8
);
  logic         valid;
  logic [W-1:0] data;

  modport master (output valid, data);
  modport slave  (input  valid, data);
endinterface

// File: rtl/error_mult_sat.sv
// Output-layer error arithmetic, one registered stage:
//   result = sat( ((actual - target) * deriv) >>> G_FRAC_BITS )
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid                : operands valid this cycle
//   actual, target, deriv   : signed fixed-point operands
//   out_valid               : result/sat valid (one cycle after in_valid)
//   result                  : signed G_ERROR_WIDTH error
//   sat                     : result was clamped
module error_mult_sat
  import nn_pack::*;
#(
  parameter int G_DATA_WIDTH  = 18,
  parameter int G_ERROR_WIDTH = 18,
  parameter int G_FRAC_BITS   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic signed [G_DATA_WIDTH-1:0]  actual,
  input  logic signed [G_DATA_WIDTH-1:0]  target,
  input  logic signed [G_DATA_WIDTH-1:0]  deriv,
  output logic                            out_valid,
  output logic signed [G_ERROR_WIDTH-1:0] result,
  output logic                            sat
);

  localparam int DW = G_DATA_WIDTH;
  localparam int EW = G_ERROR_WIDTH;

  logic signed [DW:0]      diff;
  logic signed [2*DW:0]    prod;
  logic signed [2*DW:0]    shifted;
  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] clipped;
  logic                    sat_next;

  // One extra bit keeps the difference exact before the multiply.
  assign diff     = $signed({actual[DW-1], actual}) - $signed({target[DW-1], target});
  assign prod     = diff * deriv;
  assign shifted  = prod >>> G_FRAC_BITS;
  assign wide     = SAT_W'(shifted);
  assign clipped  = sat_clip(wide, EW);
  assign sat_next = (clipped != wide);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= clipped[EW-1:0];
        sat    <= sat_next;
      end
    end
  end

endmodule

// File: rtl/output_error_gen.sv
// Output error generator: collects G_NUM_OF_NEURONS samples
// {actual, target, deriv}, turns each into a saturated error, buffers them
// and then streams the whole burst to the next layer.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : one-cycle pulse, begins a pass (ignored unless idle)
//   samples_in_st  : slave stream, data = {actual, target, deriv}
//   errors_out_st  : master stream of G_ERROR_WIDTH errors, buffer[0..N-1]
//   error_clr      : pulse the cycle after start, restarts downstream sums
//   busy           : controller not idle
//   done           : pulse in the cycle after the last streamed error
//   sat_flag       : some error of the current pass was clamped (sticky)
module output_error_gen
  import nn_pack::*;
#(
  parameter int G_DATA_WIDTH     = 18,
  parameter int G_ERROR_WIDTH    = 18,
  parameter int G_FRAC_BITS      = 8,
  parameter int G_NUM_OF_NEURONS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  dv_if.slave  samples_in_st,
  dv_if.master errors_out_st,
  output logic error_clr,
  output logic busy,
  output logic done,
  output logic sat_flag
);

  localparam int DW     = G_DATA_WIDTH;
  localparam int EW     = G_ERROR_WIDTH;
  localparam int N      = G_NUM_OF_NEURONS;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W  = $clog2(N + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(N);

  state_t               state_reg;
  logic [ADDR_W-1:0]    in_count_reg;
  logic [ADDR_W-1:0]    wr_index_reg;
  logic [IDX_W-1:0]     rd_index_reg;
  logic signed [EW-1:0] buffer_reg [N];
  logic                 out_valid_reg;
  logic [EW-1:0]        out_data_reg;
  logic                 error_clr_reg;
  logic                 done_reg;
  logic                 sat_flag_reg;

  logic                 accept;
  logic signed [DW-1:0] actual;
  logic signed [DW-1:0] target;
  logic signed [DW-1:0] deriv;
  logic                 res_valid;
  logic signed [EW-1:0] res_data;
  logic                 res_sat;

  assign accept = (state_reg == COLLECT) && samples_in_st.valid;
  assign actual = samples_in_st.data[3*DW-1 -: DW];
  assign target = samples_in_st.data[2*DW-1 -: DW];
  assign deriv  = samples_in_st.data[DW-1:0];

  error_mult_sat #(
    .G_DATA_WIDTH  (DW),
    .G_ERROR_WIDTH (EW),
    .G_FRAC_BITS   (G_FRAC_BITS)
  ) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .actual    (actual),
    .target    (target),
    .deriv     (deriv),
    .out_valid (res_valid),
    .result    (res_data),
    .sat       (res_sat)
  );

  // Error buffer, written one cycle behind acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        buffer_reg[i] <= '0;
      end
    end else if (res_valid) begin
      buffer_reg[wr_index_reg] <= res_data;
    end
  end

  // Controller. The stream outputs are registered: the FLUSH edge loads
  // buffer[0], each STREAM edge loads the next entry, and the edge after the
  // last entry drops valid and raises done while returning to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_count_reg  <= '0;
      wr_index_reg  <= '0;
      rd_index_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      error_clr_reg <= 1'b0;
      done_reg      <= 1'b0;
      sat_flag_reg  <= 1'b0;
    end else begin
      error_clr_reg <= 1'b0;
      done_reg      <= 1'b0;

      if (res_valid) begin
        wr_index_reg <= wr_index_reg + 1'b1;
        if (res_sat) begin
          sat_flag_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= COLLECT;
            in_count_reg  <= '0;
            wr_index_reg  <= '0;
            sat_flag_reg  <= 1'b0;
            error_clr_reg <= 1'b1;
          end
        end

        COLLECT: begin
          if (accept) begin
            in_count_reg <= in_count_reg + 1'b1;
            if (in_count_reg == LAST_ADDR) begin
              state_reg <= FLUSH;
            end
          end
        end

        // The last result lands in the buffer on this edge; entry 0 was
        // written long before, so it can be loaded onto the stream now.
        FLUSH: begin
          state_reg     <= STREAM;
          out_valid_reg <= 1'b1;
          out_data_reg  <= buffer_reg[0];
          rd_index_reg  <= IDX_W'(1);
        end

        STREAM: begin
          if (rd_index_reg == END_IDX) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            done_reg      <= 1'b1;
          end else begin
            out_data_reg <= buffer_reg[rd_index_reg[ADDR_W-1:0]];
            rd_index_reg <= rd_index_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign errors_out_st.valid = out_valid_reg;
  assign errors_out_st.data  = out_data_reg;
  assign error_clr           = error_clr_reg;
  assign done                = done_reg;
  assign sat_flag            = sat_flag_reg;
  assign busy                = (state_reg != IDLE);

endmodule
